// File: rtl/kernel_sched_pkg.sv
// Shared definitions for the kernel row scheduler: dtype codes, scheduler
// and flush-generator state encodings, and width/geometry helpers.
package kernel_sched_pkg;

   // Stream dtype codes. Marker beats use exact codes. Any code with a bit
   // inside DTYPE_PIXEL_MASK is a pixel.
   localparam int DTYPE_WIDTH = 8;
   localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_START = 8'h01;
   localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_END   = 8'h02;
   localparam logic [DTYPE_WIDTH-1:0] DTYPE_ROW_START   = 8'h04;
   localparam logic [DTYPE_WIDTH-1:0] DTYPE_ROW_END     = 8'h08;
   localparam logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL       = 8'h10;
   localparam logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL_MASK  = 8'hF0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_RUN   = 2'd2,
      ST_FLUSH = 2'd3
   } sched_state_t;

   typedef enum logic [2:0] {
      FG_IDLE      = 3'd0,
      FG_ROW_START = 3'd1,
      FG_PIX       = 3'd2,
      FG_ROW_END   = 3'd3,
      FG_FRAME_END = 3'd4
   } flush_phase_t;

   // Rows of fill before steady state, and rows of flush after frame end.
   function automatic int half_of(input int kernel_size);
      return kernel_size / 2;
   endfunction

   // Width of a counter that must hold 0..max_val inclusive.
   function automatic int cnt_w(input int max_val);
      return $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/kernel_flush_gen.sv
// Flush beat generator: after start, emits HALF synthetic rows of
// ROW_START, row_len x FLUSH_DTYPE, ROW_END, then a single FRAME_END.
// The current beat is presented combinationally from the phase register.
// It advances only in a cycle where ready is high. done pulses in the
// cycle the FRAME_END beat is accepted.
module kernel_flush_gen
   import kernel_sched_pkg::*;
#(
   parameter int                     HALF        = 1,
   parameter int                     COL_W       = 11,
   parameter logic [DTYPE_WIDTH-1:0] FLUSH_DTYPE = DTYPE_PIXEL
)(
   input  logic                   clk,
   input  logic                   resetb,
   input  logic                   clear,
   input  logic                   start,
   input  logic [COL_W-1:0]       row_len,
   input  logic                   ready,
   output logic [DTYPE_WIDTH-1:0] beat_dtype,
   output logic                   beat_pix,
   output logic                   done
);

   localparam int RW = cnt_w(HALF);
   localparam logic [RW-1:0] ROW_LAST = RW'(HALF - 1);

   flush_phase_t     phase;
   logic [COL_W-1:0] col_idx;
   logic [COL_W-1:0] len_q;
   logic [RW-1:0]    row_idx;

   // Beat sequencer: walks rows and columns, one step per accepted beat.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         phase   <= FG_IDLE;
         col_idx <= '0;
         row_idx <= '0;
         len_q   <= '0;
      end else if (clear) begin
         phase   <= FG_IDLE;
         col_idx <= '0;
         row_idx <= '0;
         len_q   <= '0;
      end else if (start) begin
         phase   <= FG_ROW_START;
         col_idx <= '0;
         row_idx <= '0;
         len_q   <= row_len;
      end else if (ready) begin
         case (phase)
            FG_ROW_START: begin
               col_idx <= '0;
               phase   <= (len_q == '0) ? FG_ROW_END : FG_PIX;
            end
            FG_PIX: begin
               if (col_idx == len_q - COL_W'(1)) phase <= FG_ROW_END;
               else col_idx <= col_idx + COL_W'(1);
            end
            FG_ROW_END: begin
               if (row_idx == ROW_LAST) begin
                  phase <= FG_FRAME_END;
               end else begin
                  row_idx <= row_idx + RW'(1);
                  phase   <= FG_ROW_START;
               end
            end
            FG_FRAME_END: phase <= FG_IDLE;
            default:      phase <= FG_IDLE;
         endcase
      end
   end

   // Present the dtype of the beat waiting to be accepted.
   always_comb begin
      beat_dtype = '0;
      case (phase)
         FG_ROW_START: beat_dtype = DTYPE_ROW_START;
         FG_PIX:       beat_dtype = FLUSH_DTYPE;
         FG_ROW_END:   beat_dtype = DTYPE_ROW_END;
         FG_FRAME_END: beat_dtype = DTYPE_FRAME_END;
         default:      beat_dtype = '0;
      endcase
   end

   assign beat_pix = (phase == FG_PIX);
   assign done     = ready && (phase == FG_FRAME_END);

endmodule

// File: rtl/kernel_row_scheduler.sv
// Kernel row scheduler: tracks rows/columns of one pixel stream. It drives
// the row delay buffer write/read/enable strobes. At frame end it drains the
// last KERNEL_SIZE/2 rows through kernel_flush_gen and then releases the
// held FRAME_END.
// Optional build macro KERNEL_ROW_LEN_CHECK_EN: rows after the first are
// checked against the first row's length. row_len then keeps the first
// row's value. Without it, row_len follows the most recent row.
//
// Output handshake: outside FLUSH, dvo/dtypeo are the input beat delayed one
// cycle and are never back-pressured. In FLUSH (flush_sel=1), dvo mirrors
// flush_ready and dtypeo shows the pending flush beat. A flush beat is
// consumed on the rising edge where flush_ready is high, and the next beat
// appears after that edge.
module kernel_row_scheduler
   import kernel_sched_pkg::*;
#(
   parameter int                     KERNEL_SIZE = 3,
   parameter int                     MAX_COLS    = 1288,
   parameter int                     MAX_ROWS    = 1024,
   parameter int                     RD_DELAY    = 2,
   parameter logic [DTYPE_WIDTH-1:0] FLUSH_DTYPE = DTYPE_PIXEL
)(
   input  logic                          clk,
   input  logic                          resetb,
   input  logic                          enable,
   input  logic                          dvi,
   input  logic [DTYPE_WIDTH-1:0]        dtypei,
   input  logic                          flush_ready,
   output logic                          dvo,
   output logic [DTYPE_WIDTH-1:0]        dtypeo,
   output logic                          flush_sel,
   output logic                          buf_we,
   output logic                          buf_re,
   output logic                          buf_enable,
   output logic [cnt_w(MAX_COLS)-1:0]    row_len,
   output logic                          busy,
   output logic                          err,
   output logic [1:0]                    state_dbg
);

   localparam int HALF  = half_of(KERNEL_SIZE);
   localparam int COL_W = cnt_w(MAX_COLS);
   localparam int ROW_W = cnt_w(MAX_ROWS);
   localparam logic [COL_W-1:0] COL_MAX       = COL_W'(MAX_COLS);
   localparam logic [ROW_W-1:0] ROW_MAX       = ROW_W'(MAX_ROWS);
   localparam logic [ROW_W-1:0] ROW_FILL_LAST = ROW_W'(HALF - 1);

   sched_state_t            state;
   logic                    dvo_q;
   logic [DTYPE_WIDTH-1:0]  dtypeo_q;
   logic [COL_W-1:0]        col_cnt;
   logic [ROW_W-1:0]        row_cnt;
   logic [RD_DELAY-1:0]     rd_sr;

   logic is_fs, is_fe, is_rs, is_re, pix;
   logic fg_start, fg_clear, fg_pix, fg_done, rd_in;
   logic [DTYPE_WIDTH-1:0] fg_dtype;

   assign is_fs = dvi && (dtypei == DTYPE_FRAME_START);
   assign is_fe = dvi && (dtypei == DTYPE_FRAME_END);
   assign is_rs = dvi && (dtypei == DTYPE_ROW_START);
   assign is_re = dvi && (dtypei == DTYPE_ROW_END);
   assign pix   = dvi && |(dtypei & DTYPE_PIXEL_MASK);

   // A FRAME_START while flushing abandons the flush for the new frame.
   assign fg_start = (state == ST_RUN) && is_fe;
   assign fg_clear = !enable || ((state == ST_FLUSH) && is_fs);

   kernel_flush_gen #(
      .HALF        (HALF),
      .COL_W       (COL_W),
      .FLUSH_DTYPE (FLUSH_DTYPE)
   ) u_flush_gen (
      .clk        (clk),
      .resetb     (resetb),
      .clear      (fg_clear),
      .start      (fg_start),
      .row_len    (row_len),
      .ready      (flush_ready),
      .beat_dtype (fg_dtype),
      .beat_pix   (fg_pix),
      .done       (fg_done)
   );

   // Scheduler FSM, row/column bookkeeping and registered stream outputs.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         state      <= ST_IDLE;
         dvo_q      <= 1'b0;
         dtypeo_q   <= '0;
         buf_we     <= 1'b0;
         buf_enable <= 1'b0;
         col_cnt    <= '0;
         row_cnt    <= '0;
         row_len    <= '0;
         err        <= 1'b0;
      end else if (!enable) begin
         state      <= ST_IDLE;
         dvo_q      <= 1'b0;
         dtypeo_q   <= '0;
         buf_we     <= 1'b0;
         buf_enable <= 1'b0;
         col_cnt    <= '0;
         row_cnt    <= '0;
         row_len    <= '0;
         err        <= 1'b0;
      end else begin
         buf_we     <= pix && ((state == ST_FILL) || (state == ST_RUN));
         // Pointers are cleared for the FRAME_START cycle of every new frame.
         buf_enable <= (state != ST_IDLE) && !is_fs;
         dtypeo_q   <= dtypei;
         case (state)
            ST_IDLE: begin
               dvo_q <= dvi && !is_fe;
               if (is_fs) begin
                  state   <= ST_FILL;
                  col_cnt <= '0;
                  row_cnt <= '0;
               end
            end
            ST_FILL, ST_RUN: begin
               // FRAME_END is held back in RUN and re-emitted after the flush.
               dvo_q <= dvi && !(is_fe && (state == ST_RUN));
               if (is_rs) col_cnt <= '0;
               if (pix) begin
                  if (col_cnt == COL_MAX) err <= 1'b1;
                  else col_cnt <= col_cnt + COL_W'(1);
               end
               if (is_re) begin
`ifdef KERNEL_ROW_LEN_CHECK_EN
                  if (row_cnt == '0) row_len <= col_cnt;
                  else if (col_cnt != row_len) err <= 1'b1;
`else
                  row_len <= col_cnt;
`endif
                  if (row_cnt != ROW_MAX) row_cnt <= row_cnt + ROW_W'(1);
                  if ((state == ST_FILL) && (row_cnt == ROW_FILL_LAST)) state <= ST_RUN;
               end
               if (is_fe) begin
                  if (state == ST_FILL) begin
                     // Too few rows to flush: forward FRAME_END directly.
                     err   <= 1'b1;
                     state <= ST_IDLE;
                  end else begin
                     state <= ST_FLUSH;
                  end
               end
               if (is_fs) begin
                  state   <= ST_FILL;
                  col_cnt <= '0;
                  row_cnt <= '0;
               end
            end
            ST_FLUSH: begin
               dvo_q <= 1'b0;
               if (dvi) err <= 1'b1;
               if (is_fs) begin
                  dvo_q   <= 1'b1;
                  state   <= ST_FILL;
                  col_cnt <= '0;
                  row_cnt <= '0;
               end else if (fg_done) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Read strobes for RUN pixels and accepted flush pixels.
   assign rd_in = (pix && (state == ST_RUN)) ||
                  ((state == ST_FLUSH) && flush_ready && fg_pix && !is_fs);

   // Read delay line: pending reads survive state changes and drain out.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) rd_sr <= '0;
      else if (!enable) rd_sr <= '0;
      else rd_sr <= (rd_sr << 1) | RD_DELAY'(rd_in);
   end

   assign buf_re    = rd_sr[RD_DELAY-1];
   assign flush_sel = (state == ST_FLUSH);
   assign busy      = (state == ST_FLUSH);
   assign dvo       = flush_sel ? flush_ready : dvo_q;
   assign dtypeo    = flush_sel ? fg_dtype : dtypeo_q;
   assign state_dbg = state;

endmodule

// File: doc/kernel_row_scheduler.md
Name: kernel_row_scheduler

Overview:
- Sequences the row delay buffer and the kernel front end for one pixel stream.
- Tracks rows and columns per frame and decides when the buffer writes and reads.
- At frame end it drains the last KERNEL_SIZE/2 rows by emitting synthetic flush rows, then forwards the held FRAME_END.
- Sits between the upstream dtype stream and the kernel/row_delay_buffer pair.

Parameters:
- KERNEL_SIZE, 3, kernel dimension (odd, ≥3); HALF = KERNEL_SIZE/2 rows of fill/flush.
- MAX_COLS, 1288, maximum pixels per row; sets counter widths (COL_W = $clog2(MAX_COLS+1)).
- MAX_ROWS, 1024, maximum rows per frame; ROW_W = $clog2(MAX_ROWS+1).
- RD_DELAY, 2, cycles from qualifying write pixel to buf_re; range 1..4.
- FLUSH_DTYPE, `DTYPE_PIXEL_MASK-matching code from dtypes.v, dtype used for synthetic flush pixels.

Ports:
- clk  in  1  clock.
- resetb  in  1  asynchronous active-low reset.
- enable  in  1  block enable; low acts as synchronous clear of state/counters.
- dvi  in  1  input data valid.
- dtypei  in  `DTYPE_WIDTH  input dtype.
- flush_ready  in  1  downstream accepts a flush beat this cycle.
- dvo  out  1  output valid (pass-through or flush).
- dtypeo  out  `DTYPE_WIDTH  output dtype.
- flush_sel  out  1  high while dvo/dtypeo come from the flush generator.
- buf_we  out  1  row delay buffer write enable.
- buf_re  out  1  row delay buffer read enable.
- buf_enable  out  1  buffer enable; low clears buffer pointers.
- row_len  out  COL_W  pixel count of the last completed row.
- busy  out  1  high in FLUSH; upstream must hold dvi low.
- err  out  1  sticky protocol error; cleared by reset or !enable.

Behaviour:
- Reset (resetb=0, async): state=IDLE. All outputs 0 except buf_enable=0. Counters and delay line cleared.
- !enable: same clear, applied synchronously.
- States:
  - IDLE → FILL on dvi & FRAME_START.
  - FILL → RUN when the ROW_END completing row HALF is seen.
  - RUN → FLUSH on dvi & FRAME_END.
  - FLUSH → IDLE after the held FRAME_END is emitted.
- Pass-through: in IDLE/FILL/RUN, dvo/dtypeo are dvi/dtypei registered once (latency 1). flush_sel=0. FRAME_END is not passed; it is held for the flush.
- Pixel qualifier: pix = dvi & |(dtypei & `DTYPE_PIXEL_MASK).
- buf_we = pix in FILL and RUN, registered with the same 1-cycle latency as dvo.
- buf_re = (pix & state==RUN) delayed RD_DELAY cycles through a shift register.
- buf_enable = 0 in IDLE and for the FRAME_START cycle; 1 otherwise.
- Column counter: +1 per pix, reset on ROW_START. On ROW_END, row_len <= count and the row counter increments; both saturate at MAX_COLS/MAX_ROWS.
- FLUSH sequence: HALF rows, each made of ROW_START, row_len × FLUSH_DTYPE, ROW_END, followed by the held FRAME_END. Each beat is emitted only in a cycle with flush_ready=1 (dvo=flush_ready, flush_sel=1).
- Flush reads: buf_re fires RD_DELAY cycles after each flush pixel beat. buf_we=0 during flush.
- Boundaries:
  - row_len=0: flush rows contain only ROW_START/ROW_END.
  - FRAME_END arriving in FILL: err=1, skip flush, emit FRAME_END, go IDLE.
  - dvi during FLUSH: ignored, err=1.
  - FRAME_START during FLUSH: abort flush, err=1, go FILL.
  - Column count > MAX_COLS: saturate, err=1.
- Reads already in the delay line when the state changes still complete.

Optional Feature:
- KERNEL_ROW_LEN_CHECK_EN defined: from row 2 onward, each ROW_END compares the column count against row_len. A mismatch sets err, and row_len keeps the first row's value.
- Undefined: no comparison; row_len tracks the most recent row.

Decomposition:
- State encoding (IDLE/FILL/RUN/FLUSH) and the HALF/width helper localparams go in a shared kernel_sched_pkg include alongside dtypes.v.
- One natural sub-module: kernel_flush_gen, the beat counter and dtype emitter for the flush rows, driven by start/row_len/ready and reporting done.

Test Plan:
- Basic frame, KERNEL_SIZE=3, 4 rows × 4 px, flush_ready=1 → FILL ends after row 1. buf_re count=12 during input + 4 in flush. dvo shows 1 flush row (ROW_START, 4 px, ROW_END) then FRAME_END.
- KERNEL_SIZE=5, same frame, flush_ready toggling 1010 → 2 flush rows; beats only on ready cycles. FRAME_END is the last beat. busy falls the cycle after.
- RD_DELAY=2: single pixel in RUN at cycle t → buf_re high exactly at t+2. buf_we high at t+1.
- FRAME_END during FILL (row 0 incomplete) → err=1, no flush beats, FRAME_END emitted, state IDLE.
- resetb pulsed low mid-FLUSH → all outputs 0 immediately (async). Next FRAME_START restarts cleanly with err=0.
- KERNEL_ROW_LEN_CHECK_EN: rows of 4,4,3 px → err set at third ROW_END, row_len stays 4; without the macro, row_len=3 and err=0.
